// File: rtl/vending_pkg.sv
// Shared coin codes, coin values and dispenser state encoding for the vending path.
package vending_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1    = 2'b01;
   localparam logic [1:0] COIN_2    = 2'b10;

   localparam int COIN_1_VAL = 1;
   localparam int COIN_2_VAL = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_PULSE = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } disp_state_t;

   function automatic int unsigned stk_full(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/coin_stock.sv
// Per-denomination stock counter: reset and refill load full, decrement stops at zero.
module coin_stock
   import vending_pkg::*;
#(
   parameter int STK_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             refill,
   input  logic             dec,
   output logic [STK_W-1:0] count,
   output logic             empty
);

   localparam logic [STK_W-1:0] FULL = STK_W'(stk_full(STK_W));

   // refill outranks a same-cycle decrement so the stock ends full
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= FULL;
      else if (refill)
         count <= FULL;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

   assign empty = (count == '0);

endmodule

// File: rtl/coin_dispenser.sv
// Change-payout engine: turns a refund amount into timed single-cycle coin codes,
// greedy on 2-unit coins, never overpaying, and flags a shortfall when stock runs out.
//
// state | meaning
// IDLE  | req_ready high, waiting for a refund request
// ISSUE | pick next coin (or finish); waits here while hopper_ready is low
// PULSE | chosen coin code driven for exactly one cycle
// GAP   | coin bus forced idle for GAP cycles
// DONE  | done pulse with short flag, then back to IDLE
module coin_dispenser
   import vending_pkg::*;
#(
   parameter int AMT_W = 4,
   parameter int STK_W = 6,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   input  logic             hopper_ready,
   input  logic             refill,
   output logic [1:0]       coin,
   output logic             done,
   output logic             short,
   output logic [STK_W-1:0] stock1,
   output logic [STK_W-1:0] stock2
);

   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   disp_state_t      state;
   logic [AMT_W-1:0] remaining;
   logic [3:0]       gap_cnt;
   logic             empty1, empty2;
   logic             want1, want2, dec1, dec2;

   always_comb begin
      want2 = (remaining >= AMT_W'(COIN_2_VAL)) && !empty2;
      want1 = !want2 && !empty1;
      dec2  = (state == ST_ISSUE) && (remaining != '0) && want2 && hopper_ready;
      dec1  = (state == ST_ISSUE) && (remaining != '0) && want1 && hopper_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         gap_cnt   <= '0;
         coin      <= COIN_NONE;
         done      <= 1'b0;
         short     <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         coin  <= COIN_NONE;
         done  <= 1'b0;
         short <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  remaining <= req_amount;
                  req_ready <= 1'b0;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (remaining == '0) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (want2) begin
                  if (hopper_ready) begin
                     remaining <= remaining - AMT_W'(COIN_2_VAL);
                     coin      <= COIN_2;
                     state     <= ST_PULSE;
                  end
               end else if (want1) begin
                  if (hopper_ready) begin
                     remaining <= remaining - AMT_W'(COIN_1_VAL);
                     coin      <= COIN_1;
                     state     <= ST_PULSE;
                  end
               end else begin
                  // a lone unit left with no 1-unit stock is short, never overpaid
                  done  <= 1'b1;
                  short <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_PULSE: begin
               if (GAP > 0) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end else begin
                  state <= ST_ISSUE;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0)
                  state <= ST_ISSUE;
               else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            ST_DONE: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   coin_stock #(.STK_W(STK_W)) u_stock1 (
      .clk    (clk),
      .rst    (rst),
      .refill (refill),
      .dec    (dec1),
      .count  (stock1),
      .empty  (empty1)
   );

   coin_stock #(.STK_W(STK_W)) u_stock2 (
      .clk    (clk),
      .rst    (rst),
      .refill (refill),
      .dec    (dec2),
      .count  (stock2),
      .empty  (empty2)
   );

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: directed scenarios plus randomized requests against a greedy payout model.
module tb_coin_dispenser;

   localparam int AMT_W = 4;
   localparam int STK_W = 6;
   localparam int G     = 1;
   localparam int FULL  = (1 << STK_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic [AMT_W-1:0] req_amount;
   logic             req_ready;
   logic             hopper_ready;
   logic             refill;
   logic [1:0]       coin;
   logic             done;
   logic             short;
   logic [STK_W-1:0] stock1;
   logic [STK_W-1:0] stock2;

   int total = 0;
   int bad   = 0;
   int m_s1  = FULL;
   int m_s2  = FULL;

   coin_dispenser #(.AMT_W(AMT_W), .STK_W(STK_W), .GAP(G)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_amount   (req_amount),
      .req_ready    (req_ready),
      .hopper_ready (hopper_ready),
      .refill       (refill),
      .coin         (coin),
      .done         (done),
      .short        (short),
      .stock1       (stock1),
      .stock2       (stock2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Model: greedy 2-unit first, never overpay; exact timing checked when hopper stays high.
   task automatic run_req(input string tag, input int amt, input bit rand_hop);
      int exp_coins[$];
      int obs_coins[$];
      int obs_cyc[$];
      int rem;
      int e_short;
      int cyc;
      int done_cyc;
      int got_short;
      rem     = amt;
      e_short = 0;
      while (rem > 0) begin
         if (rem >= 2 && m_s2 > 0) begin
            exp_coins.push_back(2); rem -= 2; m_s2--;
         end else if (m_s1 > 0) begin
            exp_coins.push_back(1); rem -= 1; m_s1--;
         end else begin
            e_short = 1;
            break;
         end
      end
      chk({tag, "_ready_before"}, int'(req_ready), 1);
      req_valid    = 1'b1;
      req_amount   = AMT_W'(amt);
      hopper_ready = rand_hop ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      req_valid = 1'b0;
      cyc       = 1;
      done_cyc  = -1;
      got_short = 0;
      while (cyc < 400) begin
         if (coin != 2'b00) begin
            obs_coins.push_back(int'(coin));
            obs_cyc.push_back(cyc);
         end
         if (done) begin
            done_cyc  = cyc;
            got_short = int'(short);
            break;
         end
         hopper_ready = rand_hop ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         cyc++;
      end
      hopper_ready = 1'b1;
      chk({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
      chk({tag, "_short"}, got_short, e_short);
      chk({tag, "_ncoins"}, obs_coins.size(), exp_coins.size());
      for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++) begin
         chk({tag, "_coin"}, obs_coins[i], exp_coins[i]);
         if (!rand_hop) chk({tag, "_coin_cyc"}, obs_cyc[i], 2 + i * (2 + G));
      end
      if (!rand_hop) chk({tag, "_done_cyc"}, done_cyc, 2 + exp_coins.size() * (2 + G));
      step();
      chk({tag, "_ready_after"}, int'(req_ready), 1);
      chk({tag, "_done_clr"}, int'(done), 0);
      chk({tag, "_stock1"}, int'(stock1), m_s1);
      chk({tag, "_stock2"}, int'(stock2), m_s2);
   endtask

   task automatic pulse_refill();
      refill = 1'b1;
      step();
      refill = 1'b0;
      m_s1 = FULL;
      m_s2 = FULL;
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_amount   = '0;
      hopper_ready = 1'b1;
      refill       = 1'b0;
      step();
      step();
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_coin", int'(coin), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_short", int'(short), 0);
      chk("rst_stock1", int'(stock1), FULL);
      chk("rst_stock2", int'(stock2), FULL);
      rst = 1'b0;
      step();

      run_req("amt5", 5, 1'b0);
      chk("amt5_s2", int'(stock2), FULL - 2);
      chk("amt5_s1", int'(stock1), FULL - 1);
      run_req("amt0", 0, 1'b0);

      // hopper_ready low for four cycles after accept
      hopper_ready = 1'b0;
      req_valid    = 1'b1;
      req_amount   = 4'd2;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("hop_wait_coin", int'(coin), 0);
         chk("hop_wait_ready", int'(req_ready), 0);
         step();
      end
      chk("hop_c5_coin", int'(coin), 0);
      hopper_ready = 1'b1;
      step();
      chk("hop_c6_coin", int'(coin), 2);
      m_s2--;
      step();
      chk("hop_gap_coin", int'(coin), 0);
      step();
      step();
      chk("hop_done", int'(done), 1);
      chk("hop_short", int'(short), 0);
      step();
      chk("hop_stock2", int'(stock2), m_s2);

      // refill on the same edge as a 2-unit decrement
      req_valid  = 1'b1;
      req_amount = 4'd2;
      step();
      req_valid = 1'b0;
      refill    = 1'b1;
      step();
      refill = 1'b0;
      m_s1 = FULL;
      m_s2 = FULL;
      chk("refill_coin", int'(coin), 2);
      chk("refill_stock2", int'(stock2), FULL);
      step();
      step();
      step();
      chk("refill_done", int'(done), 1);
      step();

      n = 0;
      while (m_s2 > 0 && n < 20) begin
         run_req("drain2", 15, 1'b0);
         n++;
      end
      chk("drain2_empty", int'(stock2), 0);
      run_req("ones3", 3, 1'b0);

      pulse_refill();
      n = 0;
      while (m_s1 > 0 && n < 80) begin
         run_req("drain1", 1, 1'b0);
         n++;
      end
      chk("drain1_empty", int'(stock1), 0);
      run_req("short1", 1, 1'b0);
      run_req("short3", 3, 1'b0);

      pulse_refill();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) pulse_refill();
         run_req("rnd", int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      // reset during the GAP of a 3-coin payout
      pulse_refill();
      req_valid  = 1'b1;
      req_amount = 4'd6;
      step();
      req_valid = 1'b0;
      step();
      chk("rst_mid_pulse", int'(coin), 2);
      step();
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_coin", int'(coin), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_stock2", int'(stock2), FULL);
      step();
      step();
      rst  = 1'b0;
      m_s1 = FULL;
      m_s2 = FULL;
      for (int c = 0; c < 8; c++) begin
         chk("post_rst_done", int'(done), 0);
         chk("post_rst_coin", int'(coin), 0);
         step();
      end
      chk("post_rst_ready", int'(req_ready), 1);
      chk("post_rst_stock1", int'(stock1), FULL);
      chk("post_rst_stock2", int'(stock2), FULL);
      run_req("post_rst_req", 5, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coin_dispenser.md
# coin_dispenser

Change-payout engine for the vending path. It drives the same 2-bit coin bus the coin-accepting vending FSM consumes, but as the source: it converts a requested refund amount into a timed sequence of single-cycle coin codes. It tracks on-board stock for both coin denominations and reports a shortfall when it cannot pay exactly. It sits between the vending FSM's change request and the hopper/coin-return mechanism.

## Interface
- AMT_W, 4, width of requested amount in 1-unit steps
- STK_W, 6, width of each denomination's stock counter; full stock = 2^STK_W-1
- GAP, 1, idle cycles (coin=0) forced after every dispensed coin; legal 0..15

- clk  in  1  single rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  refund request present
- req_amount  in  AMT_W  refund amount in units (1-unit coin = 1, 2-unit coin = 2)
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready at a rising edge
- hopper_ready  in  1  mechanism can take a coin this cycle
- refill  in  1  one-cycle pulse; sets both stocks to full
- coin  out  2  2'b00 none, 2'b01 one-unit coin, 2'b10 two-unit coin; 2'b11 never driven
- done  out  1  one-cycle pulse at end of every accepted request
- short  out  1  valid with done; 1 = amount not fully paid
- stock1  out  STK_W  remaining 1-unit coins
- stock2  out  STK_W  remaining 2-unit coins

## Operation
- States: IDLE, ISSUE, PULSE, GAP, DONE; all outputs are Moore or registered.
- IDLE: req_ready=1. On accept, latch req_amount into remaining and go to ISSUE.
- ISSUE: evaluate in the priority below.
  - remaining==0 -> DONE, short=0.
  - remaining>=2 and stock2>0 -> pick 2-unit.
  - else stock1>0 -> pick 1-unit.
  - else -> DONE, short=1. Never overpay: remaining==1 with stock1==0 is a shortfall, even if stock2>0.
- A coin pick transitions to PULSE only when hopper_ready=1; otherwise stay in ISSUE. On that edge: remaining -= value, chosen stock -= 1, denomination latched.
- PULSE: coin = latched code for exactly one cycle. Next state is GAP if GAP>0, else ISSUE.
- GAP: coin=0 for GAP cycles via a down-counter, then ISSUE.
- DONE: done=1 and short held for one cycle, then IDLE.
- Stock updates: refill sets both stocks to full. If refill coincides with a decrement, refill wins and the stock ends full. Stocks never wrap below 0.
- req_valid outside IDLE is ignored. Requests are not queued.

## Timing
- Reset values: state IDLE, coin=00, done=0, short=0, req_ready=1, remaining=0, gap counter=0, stock1=stock2=full.
- Reset asserted mid-payout aborts immediately: coin=00 asynchronously, no done pulse, stocks reload to full.
- Accept at edge 0 -> ISSUE in cycle 1 -> first coin visible in cycle 2 when hopper_ready=1.
- Each coin costs 2+GAP cycles (ISSUE, PULSE, GAP×GAP) when hopper_ready stays high.
- Zero-amount request: ISSUE in cycle 1, done in cycle 2, no coin.
- hopper_ready low delays only the ISSUE->PULSE edge. A coin already in PULSE is never cut short.
- Back-to-back requests: req_ready returns the cycle after DONE, so the minimum spacing between accepts is 3 cycles for amount 0.

## Structure
- vending_pkg holds:
  - coin codes COIN_NONE/COIN_1/COIN_2 and their unit values (1, 2);
  - the dispenser state enum;
  - a STK_FULL constant function of STK_W.
- One sub-module, coin_stock: a STK_W-bit counter with reset-to-full, refill priority, and decrement guarded at 0. It exposes count and empty, and is instantiated twice (stock1, stock2).
- The FSM, the remaining register, and the gap counter live in coin_dispenser.

## Test plan
- Reset, then amount=5, full stock, hopper_ready=1, GAP=1 -> coin sequence 10,00,00,10,00,00,01 starting in cycle 2. done in cycle 11 with short=0; stock2 = full-2, stock1 = full-1.
- amount=0 -> no nonzero coin; done=1, short=0 two cycles after accept.
- Preset stock2=0 (drain via prior requests, no refill), amount=3 -> three 01 coins, short=0. With stock1=0 and stock2>0, amount=1 -> done with short=1 and no coin.
- hopper_ready held low for 4 cycles after accept, amount=2 -> coin stays 00, state holds ISSUE. 10 appears the cycle after hopper_ready rises.
- refill pulse coincident with a 2-unit decrement -> stock2 reads full next cycle, and the dispensed coin is still driven.
- rst asserted during the GAP of a 3-coin payout -> coin=00 immediately, no done pulse. After release, req_ready=1 and stocks are full.
